bpb_line2: RTL and testbench
============================

Name: bpb_line2

Overview:
- One entry of the branch prediction buffer; the buffer instantiates an array of these lines and indexes them by {pc low bits, global history}.
- Each line stores a valid bit, a branch-PC tag, a target address and a 2-bit saturating counter.
- It reports, per fetch slot (2 slots), whether the slot PC matches the stored tag, and presents the stored prediction.
- The commit stage trains it through a single write port.

Parameters:
- PC_WIDTH, 32, width of word_t (PC and target address).
- TAG_LSB, 2, lowest PC bit used in the tag compare; bits below are ignored because PCs are word aligned.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  front-end stall; holds the registered prediction outputs.
- pc_predict  input  2xPC_WIDTH  fetch-slot PCs; slot 0 in [PC_WIDTH-1:0], slot 1 in the upper word.
- hit  output  2  hit[k]=1: slot k PC matches this line (registered).
- destpc_predict  output  bpb_result_t (PC_WIDTH+1)  stored prediction (registered):
  - destpc: PC_WIDTH-bit target, in the upper bits.
  - taken: 1 bit, the LSB.
- pc_commit  input  PC_WIDTH  PC of the committing branch.
- wen  input  1  write enable for this line; the parent already qualifies it with the index match.
- destpc_commit  input  bpb_result_t  resolved outcome of the committing branch: {destpc, taken}.

Behaviour:
- State: valid (1), tag (PC_WIDTH-TAG_LSB), target (PC_WIDTH), ctr (2).
  - ctr encoding: 00 strong not-taken, 01 weak NT, 10 weak taken, 11 strong taken.
  - Predicted taken = ctr[1].
- Reset (reset=1 at a clock edge): valid=0, tag=0, target=0, ctr=01; hit=2'b00; destpc_predict=0. Reset overrides wen and stall.
- Prediction (1-cycle latency), on each edge with reset=0 and stall=0:
  - hit[k] <= valid && (pc_predict[k][PC_WIDTH-1:TAG_LSB] == tag), for k=0,1.
  - destpc_predict <= {target, ctr[1]}.
  - Both slots may hit at once. destpc_predict does not depend on the slots; the parent selects per slot.
- Stall: when stall=1 (reset=0), hit and destpc_predict hold their values. Stall does NOT block training.
- Training, on each edge with reset=0 and wen=1:
  - Tag hit (valid && pc_commit tag == tag):
    - taken=1: ctr saturating +1 (11 stays 11); target <= destpc_commit.destpc.
    - taken=0: ctr saturating -1 (00 stays 00); target unchanged.
  - Miss (invalid or tag differs): replace the line.
    - valid<=1, tag<=pc_commit tag, target<=destpc_commit.destpc.
    - ctr<=10 if taken, else 01.
- Same-edge predict and train: the registered prediction samples the state from before the update. The new state is visible on the next unstalled edge.
- wen=0: state is unchanged.
- The only storage is the registered outputs and line state; there is no internal combinational path from pc_commit to the outputs.

Test Plan:
- Reset, then pc_predict={0x100,0x200}, one edge -> hit=00, destpc_predict=0.
- wen=1, pc_commit=0x1000, destpc_commit={0x2000,1}; next edge pc_predict[0]=0x1000 -> hit=01, destpc_predict={0x2000,1} (ctr=10).
- Two more taken commits to 0x1000, then four not-taken commits -> ctr path 11,11,10,01,00,00. Prediction taken: 1,1,1,0,0,0. Target stays 0x2000 throughout.
- Line holds 0x1000; commit pc 0x3000 taken to 0x4000 -> replacement. pc_predict={0x3000,0x1000} -> hit=10 (slot 1 matches), destpc_predict={0x4000,1}. pc 0x1003 vs 0x1000 -> equal tags (low bits ignored).
- stall=1 for 3 cycles while pc_predict changes and wen=1 trains -> outputs frozen. First unstalled edge shows the trained state.
- Assert reset mid-operation with wen=1 -> line invalid, hit=00 on the following prediction.

Source files
------------

// File: rtl/bpb_line2.sv
// bpb_line2: one branch prediction buffer line (valid, tag, target, 2-bit ctr).
// Ports: clk, reset, stall, pc_predict[2 slots] -> hit, destpc_predict; pc_commit, wen, destpc_commit train.
module bpb_line2 #(
  parameter int PC_WIDTH = 32,
  parameter int TAG_LSB  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [2*PC_WIDTH-1:0] pc_predict,
  output logic [1:0]            hit,
  output logic [PC_WIDTH:0]     destpc_predict,
  input  logic [PC_WIDTH-1:0]   pc_commit,
  input  logic                  wen,
  input  logic [PC_WIDTH:0]     destpc_commit
);

  localparam int TW = PC_WIDTH - TAG_LSB;

  logic          valid;
  logic [TW-1:0] tag;
  logic [PC_WIDTH-1:0] target;
  logic [1:0]    ctr;

  logic [TW-1:0] tag0;
  logic [TW-1:0] tag1;
  logic [TW-1:0] ctag;
  logic          chit;
  logic          ctaken;
  logic [PC_WIDTH-1:0] cdest;
  logic [1:0]    ctr_up;
  logic [1:0]    ctr_dn;

  assign tag0   = pc_predict[PC_WIDTH-1:TAG_LSB];
  assign tag1   = pc_predict[2*PC_WIDTH-1:PC_WIDTH+TAG_LSB];
  assign ctag   = pc_commit[PC_WIDTH-1:TAG_LSB];
  assign chit   = valid && (ctag == tag);
  assign ctaken = destpc_commit[0];
  assign cdest  = destpc_commit[PC_WIDTH:1];

  // saturating counter steps
  assign ctr_up = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
  assign ctr_dn = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid          <= 1'b0;
      tag            <= '0;
      target         <= '0;
      ctr            <= 2'b01;
      hit            <= 2'b00;
      destpc_predict <= '0;
    end else begin
      // prediction samples pre-update state
      if (!stall) begin
        hit[0]         <= valid && (tag0 == tag);
        hit[1]         <= valid && (tag1 == tag);
        destpc_predict <= {target, ctr[1]};
      end
      if (wen) begin
        if (chit) begin
          if (ctaken) begin
            ctr    <= ctr_up;
            target <= cdest;
          end else begin
            ctr    <= ctr_dn;
          end
        end else begin
          valid  <= 1'b1;
          tag    <= ctag;
          target <= cdest;
          ctr    <= ctaken ? 2'b10 : 2'b01;
        end
      end
    end
  end

endmodule

// File: tb/tb_bpb_line2.sv
// tb_bpb_line2: scoreboard bench for bpb_line2 with a queue-based reference.
// Driver pushes expected outputs per edge; monitor pops and compares.
module tb_bpb_line2;

  localparam int PW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic [2*PW-1:0] pc_predict;
  logic [1:0]      hit;
  logic [PW:0]     destpc_predict;
  logic [PW-1:0]   pc_commit;
  logic            wen;
  logic [PW:0]     destpc_commit;

  bpb_line2 #(.PC_WIDTH(PW), .TAG_LSB(2)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .pc_predict(pc_predict),
    .hit(hit),
    .destpc_predict(destpc_predict),
    .pc_commit(pc_commit),
    .wen(wen),
    .destpc_commit(destpc_commit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  h;
    logic [PW:0] d;
    int          id;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int step_id = 0;

  // reference line state
  bit        m_valid;
  bit [31:0] m_tag;
  bit [31:0] m_target;
  int        m_ctr;
  bit [1:0]  m_hit;
  bit [32:0] m_dest;

  task automatic step(input bit rst, input bit stl,
                      input bit [31:0] p0, input bit [31:0] p1,
                      input bit w, input bit [31:0] pcc,
                      input bit [31:0] dst, input bit tk);
    exp_t e;
    bit ch;
    reset = rst;
    stall = stl;
    pc_predict = {p1, p0};
    wen = w;
    pc_commit = pcc;
    destpc_commit = {dst, tk};
    if (rst) begin
      m_valid = 0; m_tag = 0; m_target = 0; m_ctr = 1;
      m_hit = 0; m_dest = 0;
    end else begin
      if (!stl) begin
        m_hit[0] = m_valid && ((p0 >> 2) == m_tag);
        m_hit[1] = m_valid && ((p1 >> 2) == m_tag);
        m_dest = {m_target, (m_ctr >= 2) ? 1'b1 : 1'b0};
      end
      if (w) begin
        ch = m_valid && ((pcc >> 2) == m_tag);
        if (ch) begin
          if (tk) begin
            m_ctr = (m_ctr == 3) ? 3 : m_ctr + 1;
            m_target = dst;
          end else begin
            m_ctr = (m_ctr == 0) ? 0 : m_ctr - 1;
          end
        end else begin
          m_valid = 1;
          m_tag = pcc >> 2;
          m_target = dst;
          m_ctr = tk ? 2 : 1;
        end
      end
    end
    e.h = m_hit;
    e.d = m_dest;
    e.id = step_id;
    step_id++;
    q.push_back(e);
    @(negedge clk);
  endtask

  // monitor: DUT presents outputs every edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) continue;
      e = q.pop_front();
      total++;
      if (hit !== e.h) begin
        bad++;
        $display("FAIL hit step=%0d got=%b want=%b", e.id, hit, e.h);
      end
      total++;
      if (destpc_predict !== e.d) begin
        bad++;
        $display("FAIL destpc step=%0d got=%h want=%h",
                 e.id, destpc_predict, e.d);
      end
    end
  end

  initial begin
    bit [31:0] pool[6];
    bit [31:0] a, b, c;
    pool[0] = 32'h1000; pool[1] = 32'h1003;
    pool[2] = 32'h3000; pool[3] = 32'h2000;
    pool[4] = 32'h3002; pool[5] = 32'h4000;
    reset = 1; stall = 0; pc_predict = '0; wen = 0;
    pc_commit = '0; destpc_commit = '0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 32'h100, 32'h200, 0, 0, 0, 0);
    // first allocate, then predict
    step(0, 0, 32'h1000, 32'h0, 1, 32'h1000, 32'h2000, 1);
    step(0, 0, 32'h1000, 32'h0, 0, 0, 0, 0);
    // two taken, four not-taken
    for (int i = 0; i < 2; i++)
      step(0, 0, 32'h1000, 32'h0, 1, 32'h1000, 32'h2000, 1);
    for (int i = 0; i < 4; i++)
      step(0, 0, 32'h1000, 32'h0, 1, 32'h1000, 32'h5555, 0);
    step(0, 0, 32'h1000, 32'h0, 0, 0, 0, 0);
    // replacement, slot 1 hit
    step(0, 0, 32'h1000, 32'h0, 1, 32'h3000, 32'h4000, 1);
    step(0, 0, 32'h1000, 32'h3000, 0, 0, 0, 0);
    // low bits ignored
    step(0, 0, 32'h3003, 32'h3001, 1, 32'h3002, 32'h4000, 1);
    step(0, 0, 32'h3003, 32'h3001, 0, 0, 0, 0);
    // stall while training
    step(0, 1, 32'h9000, 32'h1000, 1, 32'h1000, 32'h6000, 1);
    step(0, 1, 32'h1000, 32'h9000, 1, 32'h1000, 32'h6000, 0);
    step(0, 1, 32'h3000, 32'h3000, 1, 32'h1000, 32'h7000, 1);
    step(0, 0, 32'h1000, 32'h1000, 0, 0, 0, 0);
    // reset mid-operation with wen
    step(1, 0, 32'h1000, 32'h1000, 1, 32'h1000, 32'h8000, 1);
    step(0, 0, 32'h1000, 32'h1000, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      a = pool[$urandom_range(0, 5)];
      b = pool[$urandom_range(0, 5)];
      c = pool[$urandom_range(0, 5)];
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 20),
           a, b, ($urandom_range(0, 99) < 50), c,
           ($urandom & 32'hffff_fffc), $urandom_range(0, 1));
    end
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
